adam_axil_ram: RTL and testbench

- AXI-Lite slave backed by a single-port, byte-enabled on-chip RAM.
- Sits directly downstream of the top-level memory ports: one instance per entry of the memory AXI-Lite array.
- Each instance consumes one 16 MiB crossbar window (base 0x1000_0000 + 0x0100_0000*i) and honours that port's soft-reset and pause handshake.

---
 rtl/adam_mem_pkg.sv | 27 ++
 rtl/axi_lite_if.sv | 35 +++
 rtl/adam_sp_ram.sv | 37 +++
 rtl/adam_axil_ram.sv | 126 ++++++++++++
 tb/tb_adam_axil_ram.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adam_mem_pkg.sv
// Shared types and constants for the memory-window slaves.
// Holds the response encoding, the FSM state type and the window decode helper.
package adam_mem_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Each memory port owns a 16 MiB crossbar window.
    localparam int MEM_WINDOW_BITS = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRESP  = 2'd1,
        ST_RDATA  = 2'd2,
        ST_PAUSED = 2'd3
    } axil_state_t;

    // One extra bit so a full 16 MiB RAM compares correctly.
    function automatic logic in_window(input logic [MEM_WINDOW_BITS-1:0] off, input int size);
        logic [MEM_WINDOW_BITS:0] lim;
        lim = size[MEM_WINDOW_BITS:0];
        return {1'b0, off} < lim;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite request/response channels between the crossbar and a slave.
interface AXI_LITE #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/adam_sp_ram.sv
// Single-port byte-enabled RAM with registered read and no reset.
// One narrow array per byte lane so each lane maps onto a plain block RAM.
module adam_sp_ram #(
    parameter  int SIZE       = 4096,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int DEPTH      = SIZE / STRB_WIDTH,
    localparam int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [STRB_WIDTH-1:0] be,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && be[gi]) begin
                        lane_mem[addr] <= wdata[gi*8 +: 8];
                    end
                    rd_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/adam_axil_ram.sv
// AXI-Lite slave in front of a byte-enabled RAM: one outstanding transaction,
// fair write/read arbitration and a pause handshake for the peripheral controller.
module adam_axil_ram
    import adam_mem_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int SIZE       = 4096,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pause_req,
    output logic   pause_ack,
    AXI_LITE.Slave axil
);

    localparam int SIZE_BITS = $clog2(SIZE);
    localparam int BYTE_BITS = $clog2(STRB_WIDTH);
    localparam int RAM_AW    = SIZE_BITS - BYTE_BITS;

    axil_state_t state_reg, state_next;
    logic        prio_reg;      // 0: write wins a tie, 1: read wins
    resp_t       resp_reg;

    logic [MEM_WINDOW_BITS-1:0] wr_off, rd_off;
    logic                       wr_in_range, rd_in_range;
    logic                       write_avail, read_avail, can_accept;
    logic                       write_go, read_go;
    logic [RAM_AW-1:0]          ram_addr;
    logic [DATA_WIDTH-1:0]      ram_rdata;
    logic                       unused_addr_bits;

    assign wr_off      = axil.awaddr[MEM_WINDOW_BITS-1:0];
    assign rd_off      = axil.araddr[MEM_WINDOW_BITS-1:0];
    assign wr_in_range = in_window(wr_off, SIZE);
    assign rd_in_range = in_window(rd_off, SIZE);

    // Window base bits are stripped by the crossbar decode; only the offset matters here.
    assign unused_addr_bits = ^{axil.awaddr[ADDR_WIDTH-1:MEM_WINDOW_BITS],
                                axil.araddr[ADDR_WIDTH-1:MEM_WINDOW_BITS]};

    // Accepts are gated by rst so a request coinciding with reset is dropped.
    assign write_avail = axil.awvalid && axil.wvalid;
    assign read_avail  = axil.arvalid;
    assign can_accept  = (state_reg == ST_IDLE) && !pause_req && !rst;
    assign write_go    = can_accept && write_avail && (!prio_reg || !read_avail);
    assign read_go     = can_accept && read_avail && (prio_reg || !write_avail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pause_req) begin
                    state_next = ST_PAUSED;
                end else if (write_go) begin
                    state_next = ST_WRESP;
                end else if (read_go) begin
                    state_next = ST_RDATA;
                end
            end
            ST_WRESP: begin
                if (axil.bready) begin
                    state_next = pause_req ? ST_PAUSED : ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (axil.rready) begin
                    state_next = pause_req ? ST_PAUSED : ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (!pause_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        axil.awready = write_go;
        axil.wready  = write_go;
        axil.arready = read_go;
        axil.bvalid  = (state_reg == ST_WRESP);
        axil.rvalid  = (state_reg == ST_RDATA);
        axil.bresp   = (state_reg == ST_WRESP) ? resp_reg : RESP_OKAY;
        axil.rresp   = (state_reg == ST_RDATA) ? resp_reg : RESP_OKAY;
        axil.rdata   = (state_reg == ST_RDATA && resp_reg == RESP_OKAY) ? ram_rdata : '0;
        pause_ack    = (state_reg == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
            resp_reg <= RESP_OKAY;
        end else if (write_go || read_go) begin
            prio_reg <= !prio_reg;
            resp_reg <= (write_go ? wr_in_range : rd_in_range) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign ram_addr = write_go ? wr_off[SIZE_BITS-1:BYTE_BITS] : rd_off[SIZE_BITS-1:BYTE_BITS];

    adam_sp_ram #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (write_go || read_go),
        .we    (write_go && wr_in_range),
        .be    (axil.wstrb),
        .addr  (ram_addr),
        .wdata (axil.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_adam_axil_ram.sv
// Self-checking bench for adam_axil_ram: directed vector table, arbitration,
// pause and soft-reset sequences, then random traffic against a byte-array model.
module tb_adam_axil_ram;

    localparam int SIZE = 4096;

    logic clk;
    logic rst;
    logic pause_req;
    logic pause_ack;

    AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    adam_axil_ram #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SIZE       (SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .axil      (axil)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [SIZE];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int off;
        int base;
        off = int'(addr[23:0]);
        if (off >= SIZE) return 32'h0;
        base = off - (off % 4);
        return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        return (int'(addr[23:0]) < SIZE) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int off;
        int base;
        off = int'(addr[23:0]);
        if (off < SIZE) begin
            base = off - (off % 4);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[base+b] = data[b*8 +: 8];
            end
        end
    endtask

    // Starts and ends just after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int delay, output logic [1:0] resp);
        int n;
        int d;
        logic [1:0] first_resp;
        axil.awaddr  = addr;
        axil.wdata   = data;
        axil.wstrb   = strb;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        resp = 2'bxx;
        n = 0;
        @(negedge clk);
        while (!(axil.awready && axil.wready) && n < 20) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("wr_accept", {axil.awready, axil.wready}, 2'b11);
        tick();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        if (n >= 20) return;
        d = delay;
        axil.bready = (d == 0);
        @(negedge clk);
        chk("bvalid_latency", axil.bvalid, 1'b1);
        first_resp = axil.bresp;
        while (d > 0) begin
            tick();
            d--;
            axil.bready = (d == 0);
            @(negedge clk);
            chk("bvalid_hold", axil.bvalid, 1'b1);
            chk("bresp_hold", axil.bresp, first_resp);
        end
        resp = first_resp;
        tick();
        axil.bready = 1'b0;
        $display("WR addr=%08h data=%08h strb=%h bresp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int delay,
                            output logic [31:0] rdata, output logic [1:0] resp);
        int n;
        int d;
        logic [31:0] first_data;
        logic [1:0]  first_resp;
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        rdata = 32'hx;
        resp  = 2'bxx;
        n = 0;
        @(negedge clk);
        while (!axil.arready && n < 20) begin
            tick();
            n++;
            @(negedge clk);
        end
        chk("rd_accept", axil.arready, 1'b1);
        tick();
        axil.arvalid = 1'b0;
        if (n >= 20) return;
        d = delay;
        axil.rready = (d == 0);
        @(negedge clk);
        chk("rvalid_latency", axil.rvalid, 1'b1);
        first_data = axil.rdata;
        first_resp = axil.rresp;
        while (d > 0) begin
            tick();
            d--;
            axil.rready = (d == 0);
            @(negedge clk);
            chk("rvalid_hold", axil.rvalid, 1'b1);
            chk("rdata_hold", axil.rdata, first_data);
            chk("rresp_hold", axil.rresp, first_resp);
        end
        rdata = first_data;
        resp  = first_resp;
        tick();
        axil.rready = 1'b0;
        $display("RD addr=%08h rdata=%08h rresp=%0d", addr, rdata, resp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
        axil.bready  = 1'b0;
        axil.rready  = 1'b0;
        pause_req    = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          last_acc;
        int          accepts;
        int          exp_kind;
        bit          w_acc;
        bit          r_acc;

        // Reset with every request valid: nothing may be accepted.
        rst          = 1'b1;
        pause_req    = 1'b0;
        axil.awaddr  = 32'h1000_0000;
        axil.araddr  = 32'h1000_0000;
        axil.wdata   = 32'h0;
        axil.wstrb   = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.arvalid = 1'b1;
        axil.bready  = 1'b0;
        axil.rready  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_awready", axil.awready, 1'b0);
        chk("rst_wready", axil.wready, 1'b0);
        chk("rst_arready", axil.arready, 1'b0);
        chk("rst_bvalid", axil.bvalid, 1'b0);
        chk("rst_rvalid", axil.rvalid, 1'b0);
        chk("rst_bresp", axil.bresp, 2'b00);
        chk("rst_rresp", axil.rresp, 2'b00);
        chk("rst_rdata", axil.rdata, 32'h0);
        chk("rst_pause_ack", pause_ack, 1'b0);
        tick();
        rst          = 1'b0;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;

        // Directed vectors: write/readback, byte strobes, out of range.
        vecs[0] = '{1'b1, 32'h1000_0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h1000_0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h1000_0000, 32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h1000_0000, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
        vecs[4] = '{1'b0, 32'h1000_0000, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
        vecs[5] = '{1'b1, 32'h1000_1000, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[6] = '{1'b0, 32'h1000_1000, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
        vecs[8] = '{1'b0, 32'h1000_0013, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
                chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, i % 3, rdata, resp);
                chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end

        // Simultaneous write and read held valid: W first, then alternate, one per 2 cycles.
        do_reset();
        axil.awaddr  = 32'h1000_0100;
        axil.wdata   = 32'h5A5A_C3C3;
        axil.wstrb   = 4'hF;
        axil.araddr  = 32'h1000_0100;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.arvalid = 1'b1;
        axil.bready  = 1'b1;
        axil.rready  = 1'b1;
        last_acc = -1;
        accepts  = 0;
        exp_kind = 0;
        for (int cyc = 0; cyc < 40 && accepts < 8; cyc++) begin
            @(negedge clk);
            w_acc = axil.awready && axil.wready;
            r_acc = axil.arready;
            if (axil.rvalid) chk("arb_rdata", axil.rdata, 32'h5A5A_C3C3);
            if (w_acc || r_acc) begin
                chk("arb_single", {w_acc, r_acc} == 2'b11, 1'b0);
                chk("arb_order", r_acc ? 1 : 0, exp_kind);
                if (last_acc >= 0) chk("arb_spacing", cyc - last_acc, 2);
                $display("ARB cycle=%0d accept=%s", cyc, r_acc ? "R" : "W");
                exp_kind = 1 - exp_kind;
                last_acc = cyc;
                accepts++;
            end
            tick();
        end
        chk("arb_count", accepts, 8);
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axil.arvalid = 1'b0;
        repeat (2) tick();
        axil.bready = 1'b0;
        axil.rready = 1'b0;

        // Pause raised during a read response.
        axil.araddr  = 32'h1000_0010;
        axil.arvalid = 1'b1;
        @(negedge clk);
        chk("p_arready", axil.arready, 1'b1);
        tick();
        axil.arvalid = 1'b0;
        pause_req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p_rvalid_hold", axil.rvalid, 1'b1);
            chk("p_ack_early", pause_ack, 1'b0);
            tick();
        end
        axil.rready = 1'b1;
        @(negedge clk);
        chk("p_rvalid", axil.rvalid, 1'b1);
        chk("p_rdata", axil.rdata, 32'hDEADBEEF);
        tick();
        axil.rready  = 1'b0;
        axil.arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p_ack", pause_ack, 1'b1);
            chk("p_no_ar", axil.arready, 1'b0);
            chk("p_rvalid_clear", axil.rvalid, 1'b0);
            tick();
        end
        pause_req = 1'b0;
        @(negedge clk);
        chk("p_ack_hold", pause_ack, 1'b1);
        chk("p_no_ar_release", axil.arready, 1'b0);
        tick();
        @(negedge clk);
        chk("p_ack_clear", pause_ack, 1'b0);
        chk("p_ar_resume", axil.arready, 1'b1);
        tick();
        axil.arvalid = 1'b0;
        axil.rready  = 1'b1;
        @(negedge clk);
        chk("p_resume_rvalid", axil.rvalid, 1'b1);
        chk("p_resume_rdata", axil.rdata, 32'hDEADBEEF);
        tick();
        axil.rready = 1'b0;

        // One-cycle pause pulse in IDLE still passes through PAUSED.
        pause_req    = 1'b1;
        axil.arvalid = 1'b1;
        @(negedge clk);
        chk("pulse_no_ar", axil.arready, 1'b0);
        tick();
        pause_req = 1'b0;
        @(negedge clk);
        chk("pulse_ack", pause_ack, 1'b1);
        chk("pulse_no_ar2", axil.arready, 1'b0);
        tick();
        @(negedge clk);
        chk("pulse_ack_clear", pause_ack, 1'b0);
        chk("pulse_ar", axil.arready, 1'b1);
        tick();
        axil.arvalid = 1'b0;
        axil.rready  = 1'b1;
        tick();
        axil.rready = 1'b0;

        // Fill the RAM so the model knows every byte.
        for (int w = 0; w < SIZE / 4; w++) begin
            logic [31:0] a;
            logic [31:0] dat;
            a   = 32'h1000_0000 + 32'(w * 4);
            dat = $urandom;
            axi_write(a, dat, 4'hF, 0, resp);
            model_write(a, dat, 4'hF);
            chk("fill_bresp", resp, 2'b00);
        end

        // Random traffic against the byte model.
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [31:0] dat;
            logic [3:0]  strb;
            int          dly;
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a[23:0] = 24'($urandom_range(SIZE, 24'hFF_FFFF));
            else                           a[23:0] = 24'($urandom_range(0, SIZE - 1));
            dly = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                dat  = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(a, dat, strb, dly, resp);
                chk("rand_bresp", resp, model_resp(a));
                model_write(a, dat, strb);
            end else begin
                axi_read(a, dly, rdata, resp);
                chk("rand_rresp", resp, model_resp(a));
                chk("rand_rdata", rdata, model_read(a));
            end
        end

        // Soft reset with a write response pending.
        axil.awaddr  = 32'h1000_0020;
        axil.wdata   = 32'hCAFEF00D;
        axil.wstrb   = 4'hF;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        axil.bready  = 1'b0;
        @(negedge clk);
        chk("sr_accept", axil.awready && axil.wready, 1'b1);
        model_write(32'h1000_0020, 32'hCAFEF00D, 4'hF);
        tick();
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        @(negedge clk);
        chk("sr_bvalid_pending", axil.bvalid, 1'b1);
        tick();
        rst          = 1'b1;
        axil.awaddr  = 32'h1000_0024;
        axil.wdata   = 32'h0BAD_0BAD;
        axil.awvalid = 1'b1;
        axil.wvalid  = 1'b1;
        tick();
        @(negedge clk);
        chk("sr_bvalid_drop", axil.bvalid, 1'b0);
        chk("sr_pause_ack", pause_ack, 1'b0);
        chk("sr_req_ignored", axil.awready, 1'b0);
        tick();
        rst          = 1'b0;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        axi_read(32'h1000_0020, 0, rdata, resp);
        chk("sr_readback", rdata, 32'hCAFEF00D);
        chk("sr_readback_resp", resp, 2'b00);
        axi_read(32'h1000_0024, 1, rdata, resp);
        chk("sr_untouched", rdata, model_read(32'h1000_0024));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
